// File: rtl/gnn_neighbor_aggregator.sv
// Sequential neighbour aggregation for a small graph.
// On a start strobe, the block captures the features, the adjacency matrix and the mode.
// For each destination node it then walks all source nodes, one node per cycle.
// It accumulates either SUM or MAX over the neighbours that the adjacency row selects.
// Each result vector is presented with valid/ack. The neighbour count is reported with it.
//
// state | meaning
// IDLE  | waiting for in_ready; busy low
// ACCUM | folding source node src into the aggregate of node dst
// EMIT  | aggregate of dst on the outputs, held until out_ack
module gnn_neighbor_aggregator #(
  parameter int N_NODES = 4,
  parameter int N_FEAT  = 4,
  parameter int IN_W    = 5,
  parameter int ACC_W   = IN_W + $clog2(N_NODES),
  localparam int NODE_W = $clog2(N_NODES),
  localparam int DEG_W  = $clog2(N_NODES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_ready,
  input  logic                        mode,
  input  logic [N_NODES*N_FEAT*IN_W-1:0] x_flat,
  input  logic [N_NODES*N_NODES-1:0]  adj,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ack,
  output logic [NODE_W-1:0]           out_node,
  output logic [N_FEAT*ACC_W-1:0]     out_feat,
  output logic [DEG_W-1:0]            out_deg,
  output logic                        out_last
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t state_q, state_d;

  logic [N_NODES*N_FEAT*IN_W-1:0] x_q;
  logic [N_NODES*N_NODES-1:0]     adj_q;
  logic                           mode_q;
  logic [NODE_W-1:0]              dst_q;
  logic [NODE_W-1:0]              src_q;
  logic [DEG_W-1:0]               deg_q;
  logic signed [ACC_W-1:0]        acc_q  [N_FEAT];
  logic [N_FEAT-1:0]              seen_q;

  logic                           src_last;
  logic                           dst_last;
  logic                           hit;
  logic [DEG_W-1:0]               deg_d;
  logic signed [ACC_W-1:0]        acc_d  [N_FEAT];
  logic [N_FEAT-1:0]              seen_d;
  logic [IN_W-1:0]                x_in   [N_FEAT];
  logic signed [ACC_W-1:0]        x_ext  [N_FEAT];

  assign src_last = (src_q == NODE_W'(N_NODES - 1));
  assign dst_last = (dst_q == NODE_W'(N_NODES - 1));
  assign hit      = adj_q[int'(dst_q) * N_NODES + int'(src_q)];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_ready) state_d = ACCUM;
      ACCUM:   if (src_last) state_d = EMIT;
      EMIT:    if (out_ack)  state_d = dst_last ? IDLE : ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fold source node src into each feature of the running aggregate
  always_comb begin
    deg_d  = deg_q + DEG_W'(hit);
    seen_d = seen_q;
    for (int f = 0; f < N_FEAT; f++) begin
      x_in[f]  = x_q[(int'(src_q) * N_FEAT + f) * IN_W +: IN_W];
      x_ext[f] = {{(ACC_W - IN_W){x_in[f][IN_W-1]}}, x_in[f]};
      acc_d[f] = acc_q[f];
      if (hit) begin
        if (!mode_q) begin
          acc_d[f] = acc_q[f] + x_ext[f];
        end else if (!seen_q[f] || (x_ext[f] > acc_q[f])) begin
          // The first neighbour seeds MAX, so an all-negative set is not clamped at zero
          acc_d[f] = x_ext[f];
        end
        seen_d[f] = 1'b1;
      end
    end
  end

  // Capture, accumulation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      adj_q     <= '0;
      mode_q    <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      deg_q     <= '0;
      seen_q    <= '0;
      for (int f = 0; f < N_FEAT; f++) acc_q[f] <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_node  <= '0;
      out_feat  <= '0;
      out_deg   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready) begin
            x_q    <= x_flat;
            adj_q  <= adj;
            mode_q <= mode;
            dst_q  <= '0;
            src_q  <= '0;
            deg_q  <= '0;
            seen_q <= '0;
            for (int f = 0; f < N_FEAT; f++) acc_q[f] <= '0;
            busy   <= 1'b1;
          end
        end
        ACCUM: begin
          deg_q  <= deg_d;
          seen_q <= seen_d;
          for (int f = 0; f < N_FEAT; f++) acc_q[f] <= acc_d[f];
          if (src_last) begin
            src_q     <= '0;
            out_valid <= 1'b1;
            out_last  <= dst_last;
            out_node  <= dst_q;
            out_deg   <= deg_d;
            for (int f = 0; f < N_FEAT; f++) out_feat[f*ACC_W +: ACC_W] <= acc_d[f];
          end else begin
            src_q <= src_q + NODE_W'(1);
          end
        end
        EMIT: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (dst_last) begin
              busy <= 1'b0;
            end else begin
              dst_q  <= dst_q + NODE_W'(1);
              src_q  <= '0;
              deg_q  <= '0;
              seen_q <= '0;
              for (int f = 0; f < N_FEAT; f++) acc_q[f] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
